// File: rtl/elbeth_fetch_pkg.sv
// Shared types and constants for the elbeth instruction fetch stage.
package elbeth_fetch_pkg;

  localparam int         WORD_BYTES   = 4;
  localparam logic [3:0] IMEM_RW_READ = 4'b0000;
  localparam int         FETCH_ADDR_W = 8;
  localparam int         FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_ERR
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic                    error;
  } fetch_entry_t;

endpackage

// File: rtl/elbeth_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with one-cycle flush; head visible the cycle after a push.
// Push and pop may coincide at any count; the producer must never push when full.
module elbeth_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/elbeth_fetch_unit.sv
// Instruction fetch: sequential word reads from memory port A into a prefetch FIFO, one word per ready cycle.
// First instruction valid one cycle after imem_ready; fetching pauses when the buffer has no room.
module elbeth_fetch_unit
  import elbeth_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
  parameter int                    DATA_WIDTH = FETCH_DATA_W,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [3:0]            imem_rw,
  output logic [DATA_WIDTH-1:0] imem_in_data,
  input  logic [DATA_WIDTH-1:0] imem_out_data,
  input  logic                  imem_ready,
  input  logic                  imem_error,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_error,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  en_q;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          space_idle;
  logic          space_push;
  fetch_entry_t  push_ent;
  fetch_entry_t  head_ent;

  assign pop        = !empty && fetch_ready;
  assign push       = (state_q == S_REQ) && imem_ready && !redirect_valid;
  assign space_idle = !full || pop;
  // Occupancy after this cycle's push and pop must still leave a free slot to keep issuing.
  assign space_push = (count + CW'(1) - CW'(pop)) < CW'(FIFO_DEPTH);

  always_comb begin
    push_ent       = '0;
    push_ent.instr = FETCH_DATA_W'(imem_out_data);
    push_ent.pc    = FETCH_ADDR_W'(addr_q);
    push_ent.error = imem_error;
  end

  elbeth_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_o     (head_ent),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      en_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ALIGN_MASK;
      if ((state_q == S_REQ || state_q == S_DRAIN) && !imem_ready) begin
        state_q <= S_DRAIN;
      end else begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (space_idle) begin
            state_q <= S_REQ;
            en_q    <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            pc_q <= pc_q + STEP;
            if (imem_error) begin
              state_q <= S_ERR;
              en_q    <= 1'b0;
            end else if (space_push) begin
              addr_q <= pc_q + STEP;
            end else begin
              state_q <= S_IDLE;
              en_q    <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ready) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_en      = en_q;
  assign imem_addr    = addr_q;
  assign imem_rw      = IMEM_RW_READ;
  assign imem_in_data = '0;

  assign fetch_valid = !empty;
  assign fetch_instr = empty ? '0 : DATA_WIDTH'(head_ent.instr);
  assign fetch_pc    = empty ? '0 : ADDR_WIDTH'(head_ent.pc);
  assign fetch_error = !empty && head_ent.error;

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Bench for elbeth_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_elbeth_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [3:0]  imem_rw;
  logic [31:0] imem_in_data;
  logic [31:0] imem_out_data;
  logic        imem_ready;
  logic        imem_error;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [7:0]  fetch_pc;
  logic        fetch_error;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  always #5 clk = ~clk;

  elbeth_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rw        (imem_rw),
    .imem_in_data   (imem_in_data),
    .imem_out_data  (imem_out_data),
    .imem_ready     (imem_ready),
    .imem_error     (imem_error),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_error    (fetch_error),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  exp_pc;
  logic        discard;
  logic        halted;
  logic        pend;
  logic [7:0]  paddr;
  logic [31:0] salt;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return (32'(a) * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_pc  = 8'h00;
    discard = 1'b0;
    halted  = 1'b0;
    pend    = 1'b0;
    paddr   = 8'h00;
  endtask

  task automatic hold_reset();
    rst            = 1'b0;
    fetch_ready    = 1'b0;
    imem_ready     = 1'b0;
    imem_error     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    imem_out_data  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hold_reset();
    rst = 1'b1;
  endtask

  // Compare visible state after an edge with what the model says the buffer and port should hold.
  task automatic compare();
    check("valid", 32'(fetch_valid), 32'(q.size() > 0));
    if (fetch_valid && q.size() > 0) begin
      check("instr", fetch_instr, q[0].instr);
      check("pc", 32'(fetch_pc), 32'(q[0].pc));
      check("err", 32'(fetch_error), 32'(q[0].err));
    end
    if (pend) begin
      check("hold_en", 32'(imem_en), 32'h1);
      check("hold_addr", 32'(imem_addr), 32'(paddr));
    end
    if (halted) check("err_halt", 32'(imem_en), 32'h0);
    check("wr_idle", imem_in_data | 32'(imem_rw), 32'h0);
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then compare.
  task automatic cycle(input logic fr, input logic rdy, input logic err,
                       input logic redir, input logic [7:0] rpc);
    fetch_ready    = fr;
    imem_ready     = rdy;
    imem_error     = err;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_out_data  = rdy ? word_of(imem_addr) : $urandom;
    if (redir) begin
      q.delete();
      exp_pc  = rpc & 8'hFC;
      halted  = 1'b0;
      discard = imem_en && !rdy;
    end else begin
      if (fetch_valid && fr && q.size() > 0) void'(q.pop_front());
      if (imem_en && rdy) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          check("req_addr", 32'(imem_addr), 32'(exp_pc));
          q.push_back('{instr: word_of(exp_pc), pc: exp_pc, err: err});
          exp_pc = exp_pc + 8'd4;
          if (err) halted = 1'b1;
          n_done++;
        end
      end
    end
    pend  = imem_en && !rdy;
    paddr = imem_addr;
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    salt = $urandom;

    // Reset values
    hold_reset();
    check("rst_en", 32'(imem_en), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_rw", 32'(imem_rw), 32'h0);
    check("rst_wdata", imem_in_data, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'h0);
    check("rst_instr", fetch_instr, 32'h0);
    check("rst_pc", 32'(fetch_pc), 32'h0);
    check("rst_ferr", 32'(fetch_error), 32'h0);
    rst = 1'b1;

    // Streaming: memory and core always ready
    cycle(1, 1, 0, 0, 0);
    check("B_first_en", 32'(imem_en), 32'h1);
    check("B_first_addr", 32'(imem_addr), 32'h0);
    cycle(1, 1, 0, 0, 0);
    check("B_lat_valid", 32'(fetch_valid), 32'h1);
    check("B_lat_pc", 32'(fetch_pc), 32'h0);
    check("B_addr2", 32'(imem_addr), 32'h4);
    repeat (6) begin
      cycle(1, 1, 0, 0, 0);
      check("B_stream_valid", 32'(fetch_valid), 32'h1);
      check("B_pc_lag", 32'(fetch_pc), 32'(imem_addr - 8'd4));
    end

    // Core stalled: buffer fills with exactly FIFO_DEPTH words
    do_reset();
    c = 0;
    repeat (8) begin
      if (imem_en) c++;
      cycle(0, 1, 0, 0, 0);
    end
    check("C_completions", 32'(c), 32'd4);
    check("C_en_off", 32'(imem_en), 32'h0);
    check("C_head_pc", 32'(fetch_pc), 32'h0);
    for (int k = 0; k < 10 && !imem_en; k++) cycle(1, 0, 0, 0, 0);
    check("C_resume_en", 32'(imem_en), 32'h1);
    check("C_resume_addr", 32'(imem_addr), 32'h10);
    repeat (8) cycle(1, 1, 0, 0, 0);

    // Memory ready delayed three cycles
    do_reset();
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("D_held_en", 32'(imem_en), 32'h1);
    check("D_held_addr", 32'(imem_addr), 32'h0);
    check("D_no_valid", 32'(fetch_valid), 32'h0);
    cycle(0, 1, 0, 0, 0);
    check("D_one_valid", 32'(fetch_valid), 32'h1);
    check("D_one_instr", fetch_instr, word_of(8'h00));
    cycle(0, 0, 0, 0, 0);

    // Redirect while a request to 0x08 is outstanding
    do_reset();
    for (int k = 0; k < 10 && !(imem_en && imem_addr == 8'h08); k++) cycle(1, 1, 0, 0, 0);
    check("E_at_08", 32'(imem_addr), 32'h08);
    cycle(1, 0, 0, 1, 8'h41);
    check("E_flushed", 32'(fetch_valid), 32'h0);
    check("E_drain_en", 32'(imem_en), 32'h1);
    cycle(1, 1, 0, 0, 0);
    check("E_drain_done", 32'(imem_en), 32'h0);
    cycle(1, 1, 0, 0, 0);
    check("E_new_addr", 32'(imem_addr), 32'h40);
    cycle(1, 1, 0, 0, 0);
    check("E_new_pc", 32'(fetch_pc), 32'h40);

    // Access fault on 0x10 halts fetch until redirect
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (imem_en && imem_addr == 8'h10) begin
        cycle(1, 1, 1, 0, 0);
        break;
      end
      cycle(1, 1, 0, 0, 0);
    end
    check("F_err_valid", 32'(fetch_valid), 32'h1);
    check("F_err_pc", 32'(fetch_pc), 32'h10);
    check("F_err_flag", 32'(fetch_error), 32'h1);
    repeat (3) cycle(1, 1, 0, 0, 0);
    check("F_halted", 32'(imem_en), 32'h0);
    cycle(1, 1, 0, 1, 8'h20);
    cycle(1, 1, 0, 0, 0);
    check("F_restart_addr", 32'(imem_addr), 32'h20);

    // Address wrap past 0xFC
    cycle(1, 1, 0, 1, 8'hF8);
    for (int k = 0; k < 6 && !(imem_en && imem_addr == 8'hFC); k++) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("G_wrap_en", 32'(imem_en), 32'h1);
    check("G_wrap_addr", 32'(imem_addr), 32'h00);
    repeat (3) cycle(1, 1, 0, 0, 0);

    // Asynchronous reset in the middle of a pending request
    do_reset();
    cycle(1, 1, 0, 1, 8'h80);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("H_pending", 32'(imem_en), 32'h1);
    #3 rst = 1'b0;
    #1;
    check("H_async_en", 32'(imem_en), 32'h0);
    check("H_async_addr", 32'(imem_addr), 32'h0);
    check("H_async_valid", 32'(fetch_valid), 32'h0);
    hold_reset();
    rst = 1'b1;
    cycle(1, 1, 0, 0, 0);
    check("H_restart_addr", 32'(imem_addr), 32'h0);

    // Randomized traffic
    do_reset();
    n_done = 0;
    for (int i = 0; i < 3000; i++) begin
      logic fr;
      fr = ((i / 150) % 3 == 1) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
      cycle(fr, $urandom_range(2) != 0, $urandom_range(24) == 0,
            $urandom_range(39) == 0, 8'($urandom));
    end
    check("rand_progress", 32'(n_done > 500), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
